scale_gen_lanes: RTL and testbench

Multi-lane, pipelined scale generator for the PE unary/GEMM datapath. Per lane it produces the multiplier-side scale for four modes: GEMM (zero), divide (signed `y` shifted by the leading-one position of `|x|`), exp (run-time programmable exponent LUT indexed by the integer part of `x`), and log (−1). It sits between the operand fetch and the PE multiplier array. It adds LANES-wide operation, a valid/ready pipeline with backpressure, a writable LUT, and divide-by-zero saturation and flagging.

---
 rtl/scale_gen_lanes.sv | 154 +++++++++++++++
 tb/tb_scale_gen_lanes.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/scale_gen_lanes.sv
// Per-lane multiplier scale generator (gemm/div/exp/log); 2-cycle latency, 1 txn/cycle.
// Two-stage valid/ready pipeline: a stalled output holds both stages, in_ready_o follows out_ready_i combinationally.
module scale_gen_lanes #(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 16,
  parameter int LANES  = 4,
  parameter int SH_BW  = $clog2(MUL_BW)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*MUL_BW-1:0] x_i,
  input  logic [LANES*MUL_BW-1:0] y_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*MUL_BW-1:0] scale_o,
  output logic [LANES-1:0]        dz_o,
  output logic                    err_o,
  input  logic                    err_clr_i,
  input  logic                    lut_we_i,
  input  logic [INT_BW-1:0]       lut_addr_i,
  input  logic [MUL_BW-1:0]       lut_data_i
);
  localparam int DEPTH = 1 << INT_BW;
  localparam logic [1:0] MODE_GEMM = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_EXP  = 2'b10;
  localparam logic [MUL_BW-1:0] LUT_ONE = {{(MUL_BW-1){1'b0}}, 1'b1} << FRA_BW;
  localparam logic [MUL_BW-1:0] SAT_POS = {1'b0, {(MUL_BW-1){1'b1}}};
  localparam logic [MUL_BW-1:0] SAT_NEG = {1'b1, {(MUL_BW-1){1'b0}}};

  logic [MUL_BW-1:0] lut_q [DEPTH];

  logic              v1_q, v2_q, en1, en2, acc;
  logic [1:0]        mode1_q;
  logic [LANES-1:0]  s1_q, s1_d, z1_q, z1_d;
  logic [SH_BW-1:0]  p1_q [LANES];
  logic [SH_BW-1:0]  p1_d [LANES];
  logic [MUL_BW-1:0] y1_q [LANES];
  logic [MUL_BW-1:0] y1_d [LANES];
  logic [MUL_BW-1:0] lw1_q [LANES];
  logic [MUL_BW-1:0] lw1_d [LANES];
  logic [MUL_BW-1:0] x_l [LANES];
  logic [MUL_BW-1:0] m_l [LANES];

  logic signed [MUL_BW-1:0] q_l [LANES];
  logic [MUL_BW-1:0] scale2_q [LANES];
  logic [MUL_BW-1:0] scale2_d [LANES];
  logic [LANES-1:0]  dz2_q, dz2_d;
  logic              err_q, err_d;

  assign en2        = !v2_q || out_ready_i;
  assign en1        = !v1_q || en2;
  assign in_ready_o = en1;
  assign acc        = in_valid_i && en1;

  // Lookup uses the pre-write LUT contents, so a same-cycle write is seen only by later transactions.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      x_l[k]   = x_i[k*MUL_BW +: MUL_BW];
      y1_d[k]  = y_i[k*MUL_BW +: MUL_BW];
      s1_d[k]  = x_l[k][MUL_BW-1];
      m_l[k]   = s1_d[k] ? -x_l[k] : x_l[k];
      z1_d[k]  = (m_l[k] == '0);
      p1_d[k]  = '0;
      for (int i = 0; i < MUL_BW; i++) begin
        if (m_l[k][i]) p1_d[k] = SH_BW'(i);
      end
      lw1_d[k] = lut_q[x_l[k][FRA_BW +: INT_BW]];
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      q_l[k]      = $signed(y1_q[k]) >>> p1_q[k];
      dz2_d[k]    = 1'b0;
      scale2_d[k] = '0;
      case (mode1_q)
        MODE_GEMM: scale2_d[k] = '0;
        MODE_DIV: begin
          if (z1_q[k]) begin
            dz2_d[k]    = 1'b1;
            scale2_d[k] = y1_q[k][MUL_BW-1] ? SAT_NEG : SAT_POS;
          end else begin
            scale2_d[k] = s1_q[k] ? $unsigned(-q_l[k]) : $unsigned(q_l[k]);
          end
        end
        MODE_EXP: scale2_d[k] = lw1_q[k];
        default:  scale2_d[k] = '1;
      endcase
    end
  end

  // Set has priority over clear so a flagged transfer is never lost.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (v2_q && out_ready_i && (|dz2_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) lut_q[a] <= LUT_ONE;
    end else if (lut_we_i) begin
      lut_q[lut_addr_i] <= lut_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mode1_q <= MODE_GEMM;
      s1_q    <= '0;
      z1_q    <= '0;
      dz2_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        p1_q[k]     <= '0;
        y1_q[k]     <= '0;
        lw1_q[k]    <= '0;
        scale2_q[k] <= '0;
      end
    end else begin
      err_q <= err_d;
      if (en1) v1_q <= in_valid_i;
      if (acc) begin
        mode1_q <= mode_i;
        s1_q    <= s1_d;
        z1_q    <= z1_d;
        p1_q    <= p1_d;
        y1_q    <= y1_d;
        lw1_q   <= lw1_d;
      end
      if (en2) v2_q <= v1_q;
      if (en2 && v1_q) begin
        scale2_q <= scale2_d;
        dz2_q    <= dz2_d;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) scale_o[k*MUL_BW +: MUL_BW] = scale2_q[k];
  end

  assign out_valid_o = v2_q;
  assign dz_o        = dz2_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_scale_gen_lanes.sv
// Directed bench for scale_gen_lanes: reset, div, LUT write, backpressure, mode sweep, mid-run reset.
module tb_scale_gen_lanes;
  localparam int INT_BW = 5;
  localparam int FRA_BW = 10;
  localparam int MUL_BW = 16;
  localparam int LANES  = 4;
  localparam int W      = LANES * MUL_BW;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [W-1:0]      x_i, y_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [W-1:0]      scale_o;
  logic [LANES-1:0]  dz_o;
  logic              err_o;
  logic              err_clr_i;
  logic              lut_we_i;
  logic [INT_BW-1:0] lut_addr_i;
  logic [MUL_BW-1:0] lut_data_i;

  int checks = 0;
  int errors = 0;

  scale_gen_lanes #(.INT_BW(INT_BW), .FRA_BW(FRA_BW), .MUL_BW(MUL_BW), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .x_i(x_i), .y_i(y_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .scale_o(scale_o), .dz_o(dz_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .lut_we_i(lut_we_i), .lut_addr_i(lut_addr_i), .lut_data_i(lut_data_i)
  );

  always #5 clk = ~clk;

  task automatic set_tx(input logic v, input logic [1:0] m, input logic [15:0] x, input logic [15:0] y);
    in_valid_i = v;
    mode_i     = m;
    x_i        = {LANES{x}};
    y_i        = {LANES{y}};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_tx(1'b0, 2'b00, 16'h0000, 16'h0000);
    out_ready_i = 1'b1; err_clr_i = 1'b0;
    lut_we_i = 1'b0; lut_addr_i = '0; lut_data_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    checks++; if (scale_o !== 64'h0) begin errors++; $display("FAIL reset_scale: got %h want 0", scale_o); end
    checks++; if ({dz_o, err_o} !== 5'b0) begin errors++; $display("FAIL reset_dz_err: got %b/%b want 0/0", dz_o, err_o); end
    set_tx(1'b1, 2'b10, 16'h0C00, 16'h0000);
    @(negedge clk);
    set_tx(1'b0, 2'b00, 16'h0000, 16'h0000);
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL exp_reset_lut_valid: got %b want 1", out_valid_o); end
    checks++; if (scale_o !== {4{16'h0400}}) begin errors++; $display("FAIL exp_reset_lut: got %h want %h", scale_o, {4{16'h0400}}); end
    @(negedge clk);
  endtask

  task automatic test_div;
    in_valid_i = 1'b1; mode_i = 2'b01;
    x_i = {16'h0000, 16'h0001, 16'hF800, 16'h0800};
    y_i = {16'h8001, 16'h1234, 16'h4000, 16'h4000};
    @(negedge clk);
    set_tx(1'b0, 2'b00, 16'h0000, 16'h0000);
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL div_valid: got %b want 1", out_valid_o); end
    checks++; if (scale_o !== {16'h8000, 16'h1234, 16'hFFF8, 16'h0008}) begin
      errors++; $display("FAIL div_scale: got %h want %h", scale_o, {16'h8000, 16'h1234, 16'hFFF8, 16'h0008}); end
    checks++; if (dz_o !== 4'b1000) begin errors++; $display("FAIL div_dz: got %b want 1000", dz_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL div_err_early: got %b want 0", err_o); end
    @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL div_err_set: got %b want 1", err_o); end
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL div_err_clr: got %b want 0", err_o); end
  endtask

  task automatic test_lut_write;
    lut_we_i = 1'b1; lut_addr_i = 5'd1; lut_data_i = 16'h0AE0;
    set_tx(1'b1, 2'b10, 16'h0400, 16'h0000);
    @(negedge clk);
    lut_we_i = 1'b0;
    @(negedge clk);
    set_tx(1'b0, 2'b00, 16'h0000, 16'h0000);
    checks++; if (scale_o !== {4{16'h0400}}) begin errors++; $display("FAIL lut_old_value: got %h want %h", scale_o, {4{16'h0400}}); end
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL lut_new_valid: got %b want 1", out_valid_o); end
    checks++; if (scale_o !== {4{16'h0AE0}}) begin errors++; $display("FAIL lut_new_value: got %h want %h", scale_o, {4{16'h0AE0}}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int acc_cnt;
    acc_cnt = 0;
    out_ready_i = 1'b0;
    set_tx(1'b1, 2'b01, 16'h0001, 16'h0111);
    #1 if (in_valid_i && in_ready_o) acc_cnt++;
    @(negedge clk);
    set_tx(1'b1, 2'b01, 16'h0001, 16'h0222);
    #1 if (in_valid_i && in_ready_o) acc_cnt++;
    @(negedge clk);
    set_tx(1'b1, 2'b01, 16'h0001, 16'h0333);
    #1 if (in_valid_i && in_ready_o) acc_cnt++;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready_o); end
    checks++; if (scale_o !== {4{16'h0111}} || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_first_out: got %h/%b want %h/1", scale_o, out_valid_o, {4{16'h0111}}); end
    @(negedge clk);
    #1 if (in_valid_i && in_ready_o) acc_cnt++;
    checks++; if (scale_o !== {4{16'h0111}} || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got %h/%b want %h/1", scale_o, out_valid_o, {4{16'h0111}}); end
    checks++; if (acc_cnt != 2) begin errors++; $display("FAIL bp_accept_count: got %0d want 2", acc_cnt); end
    out_ready_i = 1'b1;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b want 1", in_ready_o); end
    @(negedge clk);
    set_tx(1'b0, 2'b00, 16'h0000, 16'h0000);
    checks++; if (scale_o !== {4{16'h0222}} || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_second_out: got %h/%b want %h/1", scale_o, out_valid_o, {4{16'h0222}}); end
    @(negedge clk);
    checks++; if (scale_o !== {4{16'h0333}} || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_third_out: got %h/%b want %h/1", scale_o, out_valid_o, {4{16'h0333}}); end
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid_o); end
  endtask

  task automatic test_mode_sweep;
    set_tx(1'b1, 2'b00, 16'h0C00, 16'h4000);
    @(negedge clk);
    set_tx(1'b1, 2'b11, 16'h0C00, 16'h4000);
    @(negedge clk);
    set_tx(1'b1, 2'b10, 16'h0C00, 16'h4000);
    checks++; if (scale_o !== 64'h0 || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL sweep_gemm: got %h/%b want 0/1", scale_o, out_valid_o); end
    @(negedge clk);
    set_tx(1'b1, 2'b01, 16'h0800, 16'h4000);
    checks++; if (scale_o !== {4{16'hFFFF}} || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL sweep_log: got %h/%b want %h/1", scale_o, out_valid_o, {4{16'hFFFF}}); end
    @(negedge clk);
    set_tx(1'b0, 2'b00, 16'h0000, 16'h0000);
    checks++; if (scale_o !== {4{16'h0400}} || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL sweep_exp: got %h/%b want %h/1", scale_o, out_valid_o, {4{16'h0400}}); end
    @(negedge clk);
    checks++; if (scale_o !== {4{16'h0008}} || dz_o !== 4'b0 || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL sweep_div: got %h/%b/%b want %h/0000/1", scale_o, dz_o, out_valid_o, {4{16'h0008}}); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    set_tx(1'b1, 2'b10, 16'h0400, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    set_tx(1'b0, 2'b00, 16'h0000, 16'h0000);
    #1;
    checks++; if (out_valid_o !== 1'b1 || scale_o !== {4{16'h0AE0}}) begin
      errors++; $display("FAIL midrst_before: got %h/%b want %h/1", scale_o, out_valid_o, {4{16'h0AE0}}); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0 || scale_o !== 64'h0) begin
      errors++; $display("FAIL midrst_immediate: got %h/%b want 0/0", scale_o, out_valid_o); end
    @(negedge clk);
    rst = 1'b0;
    set_tx(1'b1, 2'b10, 16'h0400, 16'h0000);
    @(negedge clk);
    set_tx(1'b0, 2'b00, 16'h0000, 16'h0000);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_discard: got %b want 0", out_valid_o); end
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1 || scale_o !== {4{16'h0400}}) begin
      errors++; $display("FAIL midrst_lut_restored: got %h/%b want %h/1", scale_o, out_valid_o, {4{16'h0400}}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_div();
    test_lut_write();
    test_back_to_back();
    test_mode_sweep();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
